// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, issue/decode scoreboard
// access and the registered regfile write port, bundled as one interface.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_rd;
  logic                      flush;
  logic [ADDR_W-1:0]         query_rj;
  logic [ADDR_W-1:0]         query_rk;
  logic [ADDR_W-1:0]         query_rd;
  logic                      stall;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      err;

  // Pipeline side: requesters, issue and decode stages.
  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, flush,
           query_rj, query_rk, query_rd,
    input  req_ready, stall, rf_we, rf_waddr, rf_wdata, err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, flush,
           query_rj, query_rk, query_rd,
    output req_ready, stall, rf_we, rf_waddr, rf_wdata, err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between
// NUM_REQ writeback sources, with a per-register busy scoreboard that
// stalls decode on operands whose producer has not yet written back.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RF_NUM  = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input logic                aclk,
  input logic                areset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [RF_NUM-1:0]  busy_reg, busy_next;
  logic               rf_we_reg;
  logic [ADDR_W-1:0]  rf_waddr_reg;
  logic [DATA_W-1:0]  rf_wdata_reg;
  logic               err_reg, err_next;
  logic               flush_d_reg;

  logic [ADDR_W-1:0]  req_rd_arr   [NUM_REQ];
  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_onehot;
  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [ADDR_W-1:0]  gnt_rd;
  logic [DATA_W-1:0]  gnt_data;
  logic               write_fire;
  logic               issue_set;
  logic               issue_conflict;
  logic               write_orphan;

  // Unpack the flat requester buses and form the one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_rd_arr[gi]   = bus.req_rd[gi*ADDR_W +: ADDR_W];
      assign req_data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      assign grant_onehot[gi] = grant_valid && !areset && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  // Round-robin scan starting at ptr; the first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ptr_reg + PTR_W'(k);
      if (!grant_valid && bus.req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign gnt_rd     = req_rd_arr[grant_idx];
  assign gnt_data   = req_data_arr[grant_idx];
  // A grant to r0 is consumed but never reaches the regfile.
  assign write_fire = grant_valid && (gnt_rd != '0);
  assign ptr_next   = grant_valid ? grant_idx + PTR_W'(1) : ptr_reg;
  assign issue_set  = bus.issue_valid && (bus.issue_rd != '0) && !bus.flush;

  // Reissuing a register whose write clears on this very edge is legal
  // (set wins); only a reissue over a still-pending producer is an error.
  assign issue_conflict = issue_set && busy_reg[bus.issue_rd] &&
                          !(write_fire && (gnt_rd == bus.issue_rd));
  // Writes to non-busy registers are tolerated during and one cycle after
  // a flush, since in-flight producers may still drain.
  assign write_orphan   = write_fire && !busy_reg[gnt_rd] &&
                          !bus.flush && !flush_d_reg;
  assign err_next       = err_reg | issue_conflict | write_orphan;

  // Scoreboard next state: flush clears everything, otherwise clear on
  // writeback then set on issue so a same-index set wins.
  always_comb begin
    busy_next = busy_reg;
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      if (write_fire) busy_next[gnt_rd] = 1'b0;
      if (issue_set)  busy_next[bus.issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Arbitration pointer, scoreboard, error flag and flush history.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_reg     <= '0;
      busy_reg    <= '0;
      err_reg     <= 1'b0;
      flush_d_reg <= 1'b0;
    end else begin
      ptr_reg     <= ptr_next;
      busy_reg    <= busy_next;
      err_reg     <= err_next;
      flush_d_reg <= bus.flush;
    end
  end

  // Registered regfile write port; address and data hold when idle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= write_fire;
      if (write_fire) begin
        rf_waddr_reg <= gnt_rd;
        rf_wdata_reg <= gnt_data;
      end
    end
  end

  assign bus.req_ready = grant_onehot;
  assign bus.rf_we     = rf_we_reg;
  assign bus.rf_waddr  = rf_waddr_reg;
  assign bus.rf_wdata  = rf_wdata_reg;
  assign bus.err       = err_reg;
  assign bus.stall     = ((bus.query_rj != '0) && busy_reg[bus.query_rj]) ||
                         ((bus.query_rk != '0) && busy_reg[bus.query_rk]) ||
                         ((bus.query_rd != '0) && busy_reg[bus.query_rd]);
endmodule
